// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter/sequencer for the shared registered 16-bit ALU.
// Optional macro ALU_ARB_DIV0_EN: intercepts divide-by-zero and answers with an error response.
module alu_arbiter #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] IDLE_FUN = 4'b1111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [3:0]       REQ0_FUN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [3:0]       REQ1_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_RES,
  input  logic [3:0]       ALU_FLAGS,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [3:0]       RSP_FLAGS,
  output logic             RSP_ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       fun;
  } req_t;

  state_t     state, state_nxt;
  req_t       req [2];
  req_t       sel;
  logic [1:0] vld;
  logic       grant, accept, last, id_q, is_div0;

  assign vld    = {REQ1_VALID, REQ0_VALID};
  assign req[0] = {REQ0_A, REQ0_B, REQ0_FUN};
  assign req[1] = {REQ1_A, REQ1_B, REQ1_FUN};

  // On a tie the client that did not win last time goes next.
  always_comb begin
    grant = vld[1];
    if (&vld) grant = ~last;
  end

  assign sel        = req[grant];
  assign accept     = (state == IDLE) && (|vld);
  assign REQ0_READY = RST && accept && !grant;
  assign REQ1_READY = RST && accept && grant;

`ifdef ALU_ARB_DIV0_EN
  assign is_div0 = (sel.fun == 4'b0011) && (sel.b == '0);
  logic rsp_err_q;
  assign RSP_ERR = rsp_err_q;
`else
  assign is_div0 = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_div0 ? RESP : ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (RSP_VALID && RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last      <= 1'b1;
      id_q      <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= IDLE_FUN;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
`ifdef ALU_ARB_DIV0_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          last <= grant;
          id_q <= grant;
          // An intercepted divide-by-zero never reaches the ALU.
          if (!is_div0) begin
            ALU_A   <= sel.a;
            ALU_B   <= sel.b;
            ALU_FUN <= sel.fun;
          end
        end
        ISSUE: begin
          ALU_A   <= '0;
          ALU_B   <= '0;
          ALU_FUN <= IDLE_FUN;
        end
        CAPTURE: begin
          RSP_VALID <= 1'b1;
          RSP_ID    <= id_q;
          RSP_DATA  <= ALU_RES;
          RSP_FLAGS <= ALU_FLAGS;
`ifdef ALU_ARB_DIV0_EN
          rsp_err_q <= 1'b0;
`endif
        end
        RESP: begin
          if (RSP_VALID && RSP_READY) RSP_VALID <= 1'b0;
`ifdef ALU_ARB_DIV0_EN
          // Only the divide-by-zero path arrives here with no response loaded.
          else if (!RSP_VALID) begin
            RSP_VALID <= 1'b1;
            RSP_ID    <= id_q;
            RSP_DATA  <= '1;
            RSP_FLAGS <= 4'b1000;
            rsp_err_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit registered ALU. Accepts operation requests (A, B, ALU_FUN) from two clients over valid/ready handshakes and drives the ALU operand and function inputs for exactly one cycle per operation. It captures the ALU result and flags one cycle later and returns them to the client through a tagged valid/ready response channel. The block sits between the client blocks and the ALU instance; it is the only driver of the ALU inputs.

## Interface
- WIDTH, 16, operand/result width; must match the ALU.
- IDLE_FUN, 4'b1111, function code driven to the ALU when no operation is issued (ALU default case: zero output, all flags 0).
- CLK  in  1  clock; every register is on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- REQ0_VALID / REQ1_VALID  in  1  request pending from client 0 / 1.
- REQ0_READY / REQ1_READY  out  1  request accepted on this edge when READY and VALID are both high.
- REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  WIDTH  operands.
- REQ0_FUN / REQ1_FUN  in  4  ALU function code.
- ALU_A, ALU_B  out  WIDTH  to ALU A/B, registered.
- ALU_FUN  out  4  to ALU ALU_FUN, registered.
- ALU_RES  in  WIDTH  from ALU ALU_OUT.
- ALU_FLAGS  in  4  from ALU, packed as {Arith_flag, Logic_flag, CMP_flag, Shift_flag}.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed on this edge when both are high.
- RSP_ID  out  1  requester index of the response.
- RSP_DATA  out  WIDTH  captured ALU result.
- RSP_FLAGS  out  4  captured flags, same packing as ALU_FLAGS.
- RSP_ERR  out  1  divide-by-zero error; see Configuration.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE → ISSUE on request acceptance. ISSUE → CAPTURE unconditionally. CAPTURE → RESP unconditionally. RESP → IDLE on RSP_VALID && RSP_READY.
- Grant is combinational and evaluated in IDLE only:
  - Exactly one VALID high: that requester is granted.
  - Both VALIDs high: the requester not equal to the LAST pointer is granted.
- REQx_READY = (state==IDLE) && grant==x. Both READYs are low in every other state.
- LAST pointer: updated to the granted index on acceptance. Reset value is 1, so client 0 wins the first tie.
- On acceptance, the granted A, B and FUN are registered onto ALU_A/ALU_B/ALU_FUN, and the ID is stored.
- In the ISSUE cycle the ALU samples its inputs. On leaving ISSUE, ALU_A/ALU_B return to 0 and ALU_FUN returns to IDLE_FUN.
- At the CAPTURE edge, ALU_RES and ALU_FLAGS are registered into RSP_DATA/RSP_FLAGS, and RSP_VALID rises.
- RSP_* outputs are held stable while RSP_VALID && !RSP_READY. They keep their values after the handshake; only RSP_VALID drops.
- Requests are not accepted on the same edge as the response handshake. Minimum spacing between acceptances is 4 cycles.
- Widths: no arithmetic is performed here. Data passes through unmodified at WIDTH bits.

## Timing
- Reset values (asynchronous on RST low):
  - state=IDLE, LAST=1.
  - ALU_A=0, ALU_B=0, ALU_FUN=IDLE_FUN.
  - RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=0.
  - REQx_READY=0 while RST is low.
- Acceptance edge E0:
  - ALU inputs valid in cycle E0–E1.
  - ALU registers its result at E1.
  - Arbiter captures at E2; RSP_VALID is high from E2.
  - Latency: 2 cycles from acceptance to RSP_VALID.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. After release, the FSM starts in IDLE with LAST=1.
- A VALID deasserted before acceptance is legal; the grant is re-evaluated each cycle.

## Configuration
- ALU_ARB_DIV0_EN defined:
  - A request with FUN=4'b0011 and B==0 is accepted normally but not issued. ALU_FUN stays IDLE_FUN.
  - The FSM goes IDLE → RESP directly. RSP_VALID is high from E1 with RSP_DATA=16'hFFFF, RSP_FLAGS=4'b1000, RSP_ERR=1.
  - RSP_ERR=0 for every other response.
- ALU_ARB_DIV0_EN not defined: division by zero is issued to the ALU like any other operation, and RSP_ERR is tied to 0.

## Test plan
- Single request: REQ0 FUN=0000, A=5, B=3 → RSP_VALID high 2 edges after acceptance with DATA=8, FLAGS=4'b1000, ID=0, ERR=0.
- Tie after reset: both valid, REQ0 SUB 10−4 and REQ1 MUL 7×6 → responses DATA=6/ID=0, then DATA=42/ID=1. A repeated tie grants REQ0 again (alternation).
- Backpressure: RSP_READY low for 5 cycles → RSP_DATA/ID/FLAGS stable, both READYs low, no acceptance until 1 edge after the handshake.
- Compare: REQ1 FUN=1011, A=9, B=2 → DATA=16'h0002, FLAGS=4'b0010, ID=1. ALU_FUN=1111 in every non-ISSUE cycle.
- Divide by zero: FUN=0011, A=7, B=0.
  - With ALU_ARB_DIV0_EN: RSP_VALID 1 edge after acceptance, DATA=16'hFFFF, ERR=1, ALU_FUN never 0011.
  - Without ALU_ARB_DIV0_EN: issued to the ALU, ERR=0.
- Reset mid-operation: RST low during CAPTURE → RSP_VALID=0 and ALU_FUN=1111 immediately, no response after release. The next tie grants REQ0.
